casex_match_seq: RTL

CASEX_MATCH_SEQ -- requirements
Module: casex_match_seq

---
 rtl/casex_match_seq.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/casex_match_seq.sv
// casex_match_seq
//
// Purpose:
//   Classifies a sampled value against a small table of masked patterns, the
//   way a casex statement with x-wildcards would. The lowest-numbered matching
//   pattern wins. A match starts a fixed-latency sequence. The pattern's result
//   code appears on value_out PRE_DLY edges after the sample. The block then
//   holds for POST_DLY edges before it can sample again. Samples that match no
//   pattern are counted in a saturating miss counter.
//
// Ports:
//   clk        in   sole clock, rising edge
//   reset      in   asynchronous, active-high reset
//   en         in   sampling enable, only looked at while idle
//   clr        in   synchronous abort back to idle (highest priority)
//   value_in   in   [WIDTH]        value to classify
//   pat_val    in   [NPAT*WIDTH]   pattern values, pattern i at [i*WIDTH +: WIDTH]
//   pat_care   in   [NPAT*WIDTH]   care masks, 1 = compare bit, 0 = wildcard
//   pat_code   in   [NPAT*OUTW]    result code per pattern
//   value_out  out  [OUTW]         registered result code
//   done       out  one-cycle pulse on the cycle value_out updates
//   busy       out  high while a sample is in flight (PRE or POST)
//   hit_idx    out  [IDXW]         index of the latched matching pattern
//   miss_cnt   out  [8]            saturating count of no-match samples

module casex_match_seq #(
    parameter int WIDTH    = 4,
    parameter int NPAT     = 3,
    parameter int OUTW     = 4,
    parameter int PRE_DLY  = 3,
    parameter int POST_DLY = 3,
    localparam int IDXW    = (NPAT > 1) ? $clog2(NPAT) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    clr,
    input  logic [WIDTH-1:0]        value_in,
    input  logic [NPAT*WIDTH-1:0]   pat_val,
    input  logic [NPAT*WIDTH-1:0]   pat_care,
    input  logic [NPAT*OUTW-1:0]    pat_code,
    output logic [OUTW-1:0]         value_out,
    output logic                    done,
    output logic                    busy,
    output logic [IDXW-1:0]         hit_idx,
    output logic [7:0]              miss_cnt
);

    // The single down-counter serves both phases, so it is sized for the longer one.
    localparam int MAXD = (PRE_DLY > POST_DLY) ? PRE_DLY : POST_DLY;
    localparam int CNTW = $clog2(MAXD + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PRE  = 2'd1;
    localparam logic [1:0] S_POST = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [OUTW-1:0] code_q, code_d;
    logic [OUTW-1:0] value_q, value_d;
    logic            done_q, done_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [7:0]      miss_q, miss_d;

    logic            anyHit;
    logic [IDXW-1:0] hitIdx;
    logic [OUTW-1:0] hitCode;

    // Pattern lookup. The loop walks from the highest index down, so a lower
    // matching index overwrites a higher one. This gives casex item-order priority.
    always_comb begin
        anyHit  = 1'b0;
        hitIdx  = '0;
        hitCode = '0;
        for (int i = NPAT - 1; i >= 0; i--) begin
            if (((value_in ^ pat_val[i*WIDTH +: WIDTH]) & pat_care[i*WIDTH +: WIDTH]) == '0) begin
                anyHit  = 1'b1;
                hitIdx  = IDXW'(i);
                hitCode = pat_code[i*OUTW +: OUTW];
            end
        end
    end

    // Sequencer. clr overrides everything, including a sample in the same cycle
    // and a PRE completion. The counter only decrements while it is above 1,
    // so it can never wrap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        value_d = value_q;
        done_d  = 1'b0;
        idx_d   = idx_q;
        miss_d  = miss_q;

        if (clr) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (en) begin
                        if (anyHit) begin
                            code_d  = hitCode;
                            idx_d   = hitIdx;
                            cnt_d   = CNTW'(PRE_DLY);
                            state_d = S_PRE;
                        end else if (miss_q != 8'hFF) begin
                            miss_d = miss_q + 8'd1;
                        end
                    end
                end
                S_PRE: begin
                    if (cnt_q <= CNTW'(1)) begin
                        value_d = code_q;
                        done_d  = 1'b1;
                        cnt_d   = CNTW'(POST_DLY);
                        state_d = S_POST;
                    end else begin
                        cnt_d = cnt_q - CNTW'(1);
                    end
                end
                S_POST: begin
                    if (cnt_q <= CNTW'(1)) begin
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q - CNTW'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State registers. Reset clears every visible output, so a sample that is
    // still in flight is dropped with no done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            code_q  <= '0;
            value_q <= '0;
            done_q  <= 1'b0;
            idx_q   <= '0;
            miss_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            value_q <= value_d;
            done_q  <= done_d;
            idx_q   <= idx_d;
            miss_q  <= miss_d;
        end
    end

    assign value_out = value_q;
    assign done      = done_q;
    assign busy      = (state_q != S_IDLE);
    assign hit_idx   = idx_q;
    assign miss_cnt  = miss_q;

endmodule
